// File: rtl/serial_bus_pkg.sv
// Shared definitions for the bit-serial bus master port: FSM state type,
// transfer-direction encodings and parameter helper functions.
package serial_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_WLOAD,
    ST_WDATA,
    ST_WACK,
    ST_RDATA,
    ST_DONE
  } state_t;

  localparam logic MODE_READ  = 1'b0;
  localparam logic MODE_WRITE = 1'b1;

  // Width of the burst-length field (words minus one).
  function automatic int len_w(input int burst_max);
    return $clog2(burst_max);
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/serial_burst_master_port_shifter.sv
// serial_shifter: right-shifting register with parallel load. Bit 0 is the
// serial output; the serial input enters at the MSB. Only the top OUT_W bits
// are exposed in parallel, which is where a received word accumulates.
module serial_shifter #(
  parameter int WIDTH = 18,
  parameter int OUT_W = 7
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             shift_en,
  input  logic             ser_in,
  output logic             ser_out,
  output logic [OUT_W-1:0] q_hi
);

  logic [WIDTH-1:0] q;

  // Load has priority over shift; both are mutually exclusive in practice.
  always_ff @(posedge clk or negedge rstn) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    if (!rstn) begin
      q <= '0;
    end else if (load) begin
      q <= load_data;
    end else if (shift_en) begin
      q <= {ser_in, q[WIDTH-1:1]};
    end
  end

  assign ser_out = q[0];
  assign q_hi    = q[WIDTH-1 -: OUT_W];

endmodule

// File: rtl/serial_burst_master_port.sv
// serial_burst_master_port: turns a parallel local request into a bit-serial
// burst on the system bus with a per-bit valid/ready handshake.
// Optional feature: define SERIAL_MASTER_TIMEOUT_EN to compile in the stall
// timeout (and the TIMEOUT parameter); otherwise stalls wait forever and
// m_err stays 0.
module serial_burst_master_port
  import serial_bus_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 8,
  parameter int BURST_MAX = 4,
`ifdef SERIAL_MASTER_TIMEOUT_EN
  parameter int TIMEOUT   = 64,
`endif
  localparam int LEN_W    = len_w(BURST_MAX)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              m_start,
  input  logic              m_mode,
  input  logic [ADDR_W-1:0] m_addr,
  input  logic [LEN_W-1:0]  m_len,
  input  logic [DATA_W-1:0] m_wr_data,
  input  logic              m_wr_valid,
  output logic              m_wr_ready,
  output logic [DATA_W-1:0] m_rd_data,
  output logic              m_rd_valid,
  output logic              m_busy,
  output logic              m_done,
  output logic              m_err,
  output logic              mode,
  output logic              wr_bus,
  input  logic              rd_bus,
  output logic              master_valid,
  input  logic              slave_ready,
  output logic              master_ready,
  input  logic              slave_valid,
  input  logic              ack
);

  localparam int HDR_BITS  = ADDR_W + LEN_W;
  localparam int SH_W      = max2(HDR_BITS, DATA_W);
  localparam int BIT_CNT_W = $clog2(SH_W + 1);

  localparam logic [BIT_CNT_W-1:0] HDR_LAST  = BIT_CNT_W'(HDR_BITS - 1);
  localparam logic [BIT_CNT_W-1:0] DATA_LAST = BIT_CNT_W'(DATA_W - 1);

  state_t                 state;
  logic [BIT_CNT_W-1:0]   bit_cnt;
  logic [LEN_W-1:0]       word_cnt;
  logic [LEN_W-1:0]       len_q;

  logic                   sh_load;
  logic [SH_W-1:0]        sh_load_data;
  logic                   sh_in;
  logic                   sh_out;
  logic [DATA_W-2:0]      sh_hi;
  logic                   xfer;
  logic                   timeout_hit;
  logic [DATA_W-1:0]      rd_word;

  // Shifter control: load the header or a write word, shift on bit transfers.
  always_comb begin
    // NOTE: every output of a combinational block gets a default up front so
    // no path leaves it unassigned and infers a latch.
    sh_load      = 1'b0;
    sh_load_data = '0;
    sh_in        = 1'b0;
    xfer         = 1'b0;
    case (state)
      ST_IDLE: begin
        if (m_start) begin
          sh_load      = 1'b1;
          sh_load_data = SH_W'({m_len, m_addr});
        end
      end
      ST_WLOAD: begin
        if (m_wr_valid) begin
          sh_load      = 1'b1;
          sh_load_data = SH_W'(m_wr_data);
        end
      end
      ST_HDR, ST_WDATA: xfer = slave_ready;
      ST_RDATA: begin
        xfer  = slave_valid;
        sh_in = rd_bus;
      end
      default: ;
    endcase
  end

  serial_shifter #(
    .WIDTH (SH_W),
    .OUT_W (DATA_W - 1)
  ) u_shifter (
    .clk       (clk),
    .rstn      (rstn),
    .load      (sh_load),
    .load_data (sh_load_data),
    .shift_en  (xfer),
    .ser_in    (sh_in),
    .ser_out   (sh_out),
    .q_hi      (sh_hi)
  );

  // The word completes on the edge that captures its last bit, so take that
  // bit straight from rd_bus alongside the bits already in the shifter.
  assign rd_word = {rd_bus, sh_hi};
  assign wr_bus  = master_valid & sh_out;

`ifdef SERIAL_MASTER_TIMEOUT_EN
  localparam int STALL_W = $clog2(TIMEOUT + 1);

  logic [STALL_W-1:0] stall_cnt;
  logic               stall_state;
  logic               progress;

  assign stall_state = state inside {ST_HDR, ST_WDATA, ST_RDATA, ST_WACK};
  assign progress    = xfer | ((state == ST_WACK) & ack);
  assign timeout_hit = stall_state & ~progress &
                       (stall_cnt == STALL_W'(TIMEOUT - 1));

  // Count consecutive cycles without progress in the bus-facing states.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stall_cnt <= '0;
    end else if (!stall_state || progress || timeout_hit) begin
      stall_cnt <= '0;
    end else begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // Transaction FSM with registered handshake and status outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= ST_IDLE;
      bit_cnt      <= '0;
      word_cnt     <= '0;
      len_q        <= '0;
      mode         <= MODE_READ;
      m_busy       <= 1'b0;
      m_done       <= 1'b0;
      m_err        <= 1'b0;
      master_valid <= 1'b0;
      master_ready <= 1'b0;
      m_wr_ready   <= 1'b0;
      m_rd_valid   <= 1'b0;
      m_rd_data    <= '0;
    end else begin
      m_done     <= 1'b0;
      m_err      <= 1'b0;
      m_rd_valid <= 1'b0;
      if (timeout_hit) begin
        state        <= ST_DONE;
        bit_cnt      <= '0;
        master_valid <= 1'b0;
        master_ready <= 1'b0;
        m_done       <= 1'b1;
        m_err        <= 1'b1;
      end else begin
        case (state)
          ST_IDLE: begin
            if (m_start) begin
              state        <= ST_HDR;
              len_q        <= m_len;
              mode         <= m_mode;
              m_busy       <= 1'b1;
              master_valid <= 1'b1;
              bit_cnt      <= '0;
              word_cnt     <= '0;
            end
          end
          ST_HDR: begin
            if (slave_ready) begin
              if (bit_cnt == HDR_LAST) begin
                bit_cnt      <= '0;
                master_valid <= 1'b0;
                if (mode == MODE_WRITE) begin
                  state      <= ST_WLOAD;
                  m_wr_ready <= 1'b1;
                end else begin
                  state        <= ST_RDATA;
                  master_ready <= 1'b1;
                end
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
          end
          ST_WLOAD: begin
            if (m_wr_valid) begin
              state        <= ST_WDATA;
              m_wr_ready   <= 1'b0;
              master_valid <= 1'b1;
              bit_cnt      <= '0;
            end
          end
          ST_WDATA: begin
            if (slave_ready) begin
              if (bit_cnt == DATA_LAST) begin
                bit_cnt      <= '0;
                master_valid <= 1'b0;
                if (word_cnt == len_q) begin
                  state <= ST_WACK;
                end else begin
                  word_cnt   <= word_cnt + 1'b1;
                  state      <= ST_WLOAD;
                  m_wr_ready <= 1'b1;
                end
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
          end
          ST_WACK: begin
            if (ack) begin
              state  <= ST_DONE;
              m_done <= 1'b1;
            end
          end
          ST_RDATA: begin
            if (slave_valid) begin
              if (bit_cnt == DATA_LAST) begin
                bit_cnt    <= '0;
                m_rd_data  <= rd_word;
                m_rd_valid <= 1'b1;
                if (word_cnt == len_q) begin
                  state        <= ST_DONE;
                  master_ready <= 1'b0;
                  m_done       <= 1'b1;
                end else begin
                  word_cnt <= word_cnt + 1'b1;
                end
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
          end
          ST_DONE: begin
            state  <= ST_IDLE;
            m_busy <= 1'b0;
            mode   <= MODE_READ;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_serial_burst_master_port.sv
// Scoreboard bench for serial_burst_master_port: the driver pushes expected
// serial bits, read words and completion status; a negedge monitor pops and
// compares whenever the DUT presents a bit transfer, read word or m_done.
module tb_serial_burst_master_port;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        m_start = 1'b0;
  logic        m_mode = 1'b0;
  logic [15:0] m_addr = '0;
  logic [1:0]  m_len = '0;
  logic [7:0]  m_wr_data = '0;
  logic        m_wr_valid = 1'b0;
  logic        m_wr_ready;
  logic [7:0]  m_rd_data;
  logic        m_rd_valid;
  logic        m_busy;
  logic        m_done;
  logic        m_err;
  logic        mode;
  logic        wr_bus;
  logic        rd_bus = 1'b0;
  logic        master_valid;
  logic        slave_ready = 1'b0;
  logic        master_ready;
  logic        slave_valid = 1'b0;
  logic        ack = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int c0 = 0;
  int done_cyc = -1;

  bit         exp_bits[$];
  logic [7:0] exp_rd[$];
  bit         exp_done[$];

  serial_burst_master_port dut (
    .clk          (clk),
    .rstn         (rstn),
    .m_start      (m_start),
    .m_mode       (m_mode),
    .m_addr       (m_addr),
    .m_len        (m_len),
    .m_wr_data    (m_wr_data),
    .m_wr_valid   (m_wr_valid),
    .m_wr_ready   (m_wr_ready),
    .m_rd_data    (m_rd_data),
    .m_rd_valid   (m_rd_valid),
    .m_busy       (m_busy),
    .m_done       (m_done),
    .m_err        (m_err),
    .mode         (mode),
    .wr_bus       (wr_bus),
    .rd_bus       (rd_bus),
    .master_valid (master_valid),
    .slave_ready  (slave_ready),
    .master_ready (master_ready),
    .slave_valid  (slave_valid),
    .ack          (ack)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compare every DUT-presented event against the scoreboard.
  always @(negedge clk) begin
    if (rstn) begin
      if (master_valid && slave_ready) begin
        if (exp_bits.size() > 0) check("wr_bus", wr_bus, exp_bits.pop_front());
        else check("wr_xfer_unexpected", master_valid, 0);
      end
      if (m_rd_valid) begin
        if (exp_rd.size() > 0) check("rd_data", m_rd_data, exp_rd.pop_front());
        else check("rd_valid_unexpected", m_rd_valid, 0);
      end
      if (m_done) begin
        done_cyc = cyc;
        if (exp_done.size() > 0) check("m_err", m_err, exp_done.pop_front());
        else check("done_unexpected", m_done, 0);
      end
    end
  end

  task automatic start_txn(input logic md, input logic [15:0] addr,
                           input logic [1:0] len, input bit err_exp);
    @(posedge clk); #1;
    m_start = 1'b1; m_mode = md; m_addr = addr; m_len = len;
    c0 = cyc;
    for (int i = 0; i < 16; i++) exp_bits.push_back(addr[i]);
    for (int i = 0; i < 2; i++) exp_bits.push_back(len[i]);
    exp_done.push_back(err_exp);
    @(posedge clk); #1;
    m_start = 1'b0;
  endtask

  task automatic push_word(input logic [7:0] d);
    for (int i = 0; i < 8; i++) exp_bits.push_back(d[i]);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (m_busy && n < budget);
    check("idle_wait", m_busy, 0);
  endtask

  task automatic wait_wr_ready();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!m_wr_ready && n < 100);
    if (!m_wr_ready) check("wr_ready_wait", m_wr_ready, 1);
  endtask

  task automatic wait_master_ready();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!master_ready && n < 100);
    if (!master_ready) check("master_ready_wait", master_ready, 1);
  endtask

  task automatic check_queues_empty(input string tag);
    check({tag, "_bits_left"}, exp_bits.size(), 0);
    check({tag, "_rd_left"}, exp_rd.size(), 0);
    check({tag, "_done_left"}, exp_done.size(), 0);
  endtask

  task automatic check_all_zero(input string tag);
    check(tag, {m_wr_ready, m_rd_data, m_rd_valid, m_busy, m_done, m_err,
                mode, wr_bus, master_valid, master_ready}, 0);
  endtask

  initial begin
    logic [7:0] words [4];
    logic [15:0] rd_stream;
    words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33; words[3] = 8'h44;

    // Reset state
    #2;
    check_all_zero("reset_outputs");
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    check_all_zero("idle_outputs");

    // Single write: header abcd/00, data d3, ack in cycle 28, done in 29
    slave_ready = 1'b1; m_wr_valid = 1'b1; m_wr_data = 8'hd3;
    start_txn(1'b1, 16'habcd, 2'd0, 1'b0);
    push_word(8'hd3);
    @(negedge clk);
    check("wr1_busy", m_busy, 1);
    check("wr1_mode", mode, 1);
    check("wr1_mvalid", master_valid, 1);
    repeat (27) @(posedge clk);
    #1 ack = 1'b1;
    @(negedge clk);
    check("wr1_wack_mvalid", master_valid, 0);
    wait_idle(50);
    ack = 1'b0; m_wr_valid = 1'b0;
    check("wr1_done_cycle", done_cyc - c0, 29);
    check("wr1_idle_mode", mode, 0);
    check_queues_empty("wr1");

    // Burst write of 4 words with a 5-cycle local stall before word 2
    ack = 1'b1;
    start_txn(1'b1, 16'h5a3c, 2'd3, 1'b0);
    for (int k = 0; k < 4; k++) push_word(words[k]);
    for (int k = 0; k < 4; k++) begin
      m_wr_data = words[k];
      if (k == 1) begin
        wait_wr_ready();
        check("stall_mvalid", master_valid, 0);
        repeat (4) begin
          @(negedge clk);
          check("stall_mvalid", master_valid, 0);
          check("stall_wr_ready", m_wr_ready, 1);
        end
        @(posedge clk); #1;
      end
      m_wr_valid = 1'b1;
      wait_wr_ready();
      @(posedge clk); #1;
      m_wr_valid = 1'b0;
    end
    wait_idle(100);
    check("burst_done_cycle", done_cyc - c0, 61);
    check_queues_empty("burst");
    ack = 1'b0;

    // Read burst of 2 words, slave_valid toggling every cycle
    rd_stream = {8'h3c, 8'ha5};
    exp_rd.push_back(8'ha5);
    exp_rd.push_back(8'h3c);
    start_txn(1'b0, 16'h0010, 2'd1, 1'b0);
    wait_master_ready();
    check("rd_mode", mode, 0);
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++) begin
      slave_valid = 1'b1; rd_bus = rd_stream[i];
      @(posedge clk); #1;
      slave_valid = 1'b0; rd_bus = 1'b0;
      @(posedge clk); #1;
    end
    wait_idle(50);
    check("rd_done_cycle", done_cyc - c0, 51);
    check("rd_last_word", m_rd_data, 8'h3c);
    check_queues_empty("rd");

    // slave_ready low for 3 cycles mid-header: bit held, header length same
    m_wr_valid = 1'b1; m_wr_data = 8'h5a; ack = 1'b1;
    start_txn(1'b1, 16'h1234, 2'd0, 1'b0);
    push_word(8'h5a);
    repeat (4) @(posedge clk);
    #1 slave_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("hdr_hold_bit", wr_bus, 1'b1);  // bit 4 of 16'h1234
      check("hdr_hold_mvalid", master_valid, 1);
      @(posedge clk); #1;
    end
    slave_ready = 1'b1;
    wait_idle(60);
    check("hdr_stall_done_cycle", done_cyc - c0, 32);
    check_queues_empty("hdr_stall");
    m_wr_valid = 1'b0; ack = 1'b0;

`ifdef SERIAL_MASTER_TIMEOUT_EN
    // Write with ack never asserted: abort 64 cycles after WACK entry (28)
    m_wr_valid = 1'b1; m_wr_data = 8'he7;
    start_txn(1'b1, 16'h0f00, 2'd0, 1'b1);
    push_word(8'he7);
    wait_idle(200);
    check("timeout_done_cycle", done_cyc - c0, 92);
    check("timeout_idle_mvalid", master_valid, 0);
    check_queues_empty("timeout");
    m_wr_valid = 1'b0;
`endif

    // Reset in the middle of a read, then a clean new write
    start_txn(1'b0, 16'h00ff, 2'd0, 1'b0);
    wait_master_ready();
    @(posedge clk); #1;
    slave_valid = 1'b1; rd_bus = 1'b1;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b0; slave_valid = 1'b0; rd_bus = 1'b0;
    #2;
    check_all_zero("midrd_reset_outputs");
    exp_bits.delete(); exp_rd.delete(); exp_done.delete();
    @(posedge clk); #1 rstn = 1'b1;
    m_wr_valid = 1'b1; m_wr_data = 8'h96; ack = 1'b1;
    start_txn(1'b1, 16'h0f0f, 2'd0, 1'b0);
    push_word(8'h96);
    @(negedge clk);
    check("post_reset_mvalid", master_valid, 1);
    check("post_reset_busy", m_busy, 1);
    wait_idle(60);
    check("post_reset_done_cycle", done_cyc - c0, 29);
    check_queues_empty("post_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
